// File: rtl/mig_write_sequencer_if.sv
// Bus bundle between the write sequencer, the clock-crossing FIFO read ports and the MIG user interface.
// The master side is the sequencer and the slave side is the FIFOs plus the MIG.
interface mig_write_sequencer_if;
  logic         cmd_fifo_rd_en;
  logic [29:0]  cmd_fifo_rd_data;
  logic [8:0]   cmd_fifo_rd_size;
  logic         data_fifo_rd_en;
  logic [255:0] data_fifo_rd_data;
  logic [9:0]   data_fifo_rd_size;
  logic [28:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [255:0] app_wdf_data;
  logic         app_wdf_end;
  logic [31:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_rdy;
  logic         app_ref_req;
  logic         app_sr_req;
  logic         app_zq_req;

  modport master (
    output cmd_fifo_rd_en, data_fifo_rd_en,
           app_addr, app_cmd, app_en,
           app_wdf_data, app_wdf_end, app_wdf_mask, app_wdf_wren,
           app_ref_req, app_sr_req, app_zq_req,
    input  cmd_fifo_rd_data, cmd_fifo_rd_size,
           data_fifo_rd_data, data_fifo_rd_size,
           app_rdy, app_wdf_rdy
  );

  modport slave (
    input  cmd_fifo_rd_en, data_fifo_rd_en,
           app_addr, app_cmd, app_en,
           app_wdf_data, app_wdf_end, app_wdf_mask, app_wdf_wren,
           app_ref_req, app_sr_req, app_zq_req,
    output cmd_fifo_rd_data, cmd_fifo_rd_size,
           data_fifo_rd_data, data_fifo_rd_size,
           app_rdy, app_wdf_rdy
  );
endinterface

// File: rtl/mig_write_sequencer.sv
// Pops one command and two data words per burst from the CDC FIFOs and issues them to the MIG
// user interface with independent command/data handshakes; keeps burst and stall counters.
//
// state | meaning
// IDLE  | waiting for enable plus one command and two data words
// POP0  | pop command and first data word
// POP1  | pop second data word; capture command and first data word
// CAPT  | capture second data word; drop read commands or load the MIG outputs
// ISSUE | command and write data handshaked with the MIG independently
module mig_write_sequencer #(
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter logic [31:0] WDF_MASK      = 32'h0
) (
  input  logic                     clk_ram,
  input  logic                     rst_n,
  input  logic                     enable,
  mig_write_sequencer_if.master    bus,
  output logic                     busy,
  output logic                     cmd_err,
  output logic [COUNTER_WIDTH-1:0] bursts_done,
  output logic [COUNTER_WIDTH-1:0] stall_cycles
);

  typedef enum logic [2:0] {IDLE, POP0, POP1, CAPT, ISSUE} state_t;

  state_t       state;
  logic [29:0]  cmd_reg;
  logic [255:0] d0;
  logic [255:0] d1;
  logic         cmd_done;
  logic         beat;

  logic start;
  logic cmd_acc;
  logic wdf_acc;
  logic cmd_done_nxt;
  logic data_done_nxt;
  logic stall;

  assign start   = enable && (bus.cmd_fifo_rd_size != 9'd0) && (bus.data_fifo_rd_size >= 10'd2);
  assign cmd_acc = bus.app_en & bus.app_rdy;
  assign wdf_acc = bus.app_wdf_wren & bus.app_wdf_rdy;
  assign stall   = (bus.app_en & ~bus.app_rdy) | (bus.app_wdf_wren & ~bus.app_wdf_rdy);

  // Completion may coincide with the final handshakes, so look at next-cycle status.
  assign cmd_done_nxt  = cmd_done | cmd_acc;
  assign data_done_nxt = beat & (wdf_acc | ~bus.app_wdf_wren);

  assign bus.cmd_fifo_rd_en  = (state == POP0);
  assign bus.data_fifo_rd_en = (state == POP0) || (state == POP1);
  assign bus.app_wdf_mask    = WDF_MASK;
  assign bus.app_ref_req     = 1'b0;
  assign bus.app_sr_req      = 1'b0;
  assign bus.app_zq_req      = 1'b0;
  assign busy                = (state != IDLE);

  always_ff @(posedge clk_ram) begin
    if (!rst_n) begin
      state            <= IDLE;
      cmd_reg          <= '0;
      d0               <= '0;
      d1               <= '0;
      cmd_done         <= 1'b0;
      beat             <= 1'b0;
      cmd_err          <= 1'b0;
      bursts_done      <= '0;
      stall_cycles     <= '0;
      bus.app_addr     <= '0;
      bus.app_cmd      <= '0;
      bus.app_en       <= 1'b0;
      bus.app_wdf_data <= '0;
      bus.app_wdf_end  <= 1'b0;
      bus.app_wdf_wren <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) state <= POP0;
        POP0: state <= POP1;
        POP1: begin
          cmd_reg <= bus.cmd_fifo_rd_data;
          d0      <= bus.data_fifo_rd_data;
          state   <= CAPT;
        end
        CAPT: begin
          d1 <= bus.data_fifo_rd_data;
          if (cmd_reg[29]) begin
            cmd_err <= 1'b1;
            state   <= IDLE;
          end else begin
            bus.app_en       <= 1'b1;
            bus.app_addr     <= cmd_reg[28:0];
            bus.app_cmd      <= 3'b000;
            bus.app_wdf_wren <= 1'b1;
            bus.app_wdf_data <= d0;
            bus.app_wdf_end  <= 1'b0;
            cmd_done         <= 1'b0;
            beat             <= 1'b0;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_acc) begin
            bus.app_en <= 1'b0;
            cmd_done   <= 1'b1;
          end
          if (wdf_acc) begin
            if (!beat) begin
              bus.app_wdf_data <= d1;
              bus.app_wdf_end  <= 1'b1;
              beat             <= 1'b1;
            end else begin
              bus.app_wdf_wren <= 1'b0;
              bus.app_wdf_end  <= 1'b0;
            end
          end
          if (stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + COUNTER_WIDTH'(1);
          if (cmd_done_nxt && data_done_nxt) begin
            state <= IDLE;
            if (bursts_done != '1)
              bursts_done <= bursts_done + COUNTER_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mig_write_sequencer.sv
// Bench for mig_write_sequencer: models both CDC FIFOs and a MIG with scripted ready lines,
// and scoreboards every accepted command and write beat against what was queued.
module tb_mig_write_sequencer;
  localparam int CW = 32;

  logic          clk_ram = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          busy;
  logic          cmd_err;
  logic [CW-1:0] bursts_done;
  logic [CW-1:0] stall_cycles;

  mig_write_sequencer_if bus ();

  mig_write_sequencer #(.COUNTER_WIDTH(CW), .WDF_MASK(32'h0)) dut (
    .clk_ram      (clk_ram),
    .rst_n        (rst_n),
    .enable       (enable),
    .bus          (bus),
    .busy         (busy),
    .cmd_err      (cmd_err),
    .bursts_done  (bursts_done),
    .stall_cycles (stall_cycles)
  );

  always #5 clk_ram = ~clk_ram;

  typedef struct packed {
    logic [255:0] data;
    logic         last;
  } beat_t;

  logic [29:0]  cmdq[$];
  logic [255:0] dataq[$];
  logic [28:0]  exp_addr[$];
  beat_t        exp_beat[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_cmd_pop, n_data_pop, n_cmd_acc, n_wdf_acc;
  logic saw_app_en, saw_wren;
  logic [CW-1:0] exp_bursts;
  logic [CW-1:0] exp_stall;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic update_sizes();
    bus.cmd_fifo_rd_size  = 9'(cmdq.size());
    bus.data_fifo_rd_size = 10'(dataq.size());
  endtask

  task automatic push_burst(input logic [28:0] addr, input logic [255:0] a, input logic [255:0] b);
    cmdq.push_back({1'b0, addr});
    dataq.push_back(a);
    dataq.push_back(b);
    exp_addr.push_back(addr);
    exp_beat.push_back('{data: a, last: 1'b0});
    exp_beat.push_back('{data: b, last: 1'b1});
    update_sizes();
  endtask

  task automatic clear_stats();
    n_cmd_pop = 0; n_data_pop = 0; n_cmd_acc = 0; n_wdf_acc = 0;
    saw_app_en = 1'b0; saw_wren = 1'b0;
  endtask

  // One clock: score what the edge will accept, model FIFO pops, then move to 1 time unit after the edge.
  task automatic tick();
    logic [29:0]  next_cmd;
    logic [255:0] next_data;
    logic [28:0]  ea;
    beat_t        eb;
    next_cmd  = bus.cmd_fifo_rd_data;
    next_data = bus.data_fifo_rd_data;
    if (bus.app_en) saw_app_en = 1'b1;
    if (bus.app_wdf_wren) saw_wren = 1'b1;
    if (rst_n && bus.app_en && bus.app_rdy) begin
      n_cmd_acc++;
      check_val("cmd_expected", 256'(exp_addr.size() != 0), 256'(1));
      if (exp_addr.size() != 0) begin
        ea = exp_addr.pop_front();
        check_val("app_addr", 256'(bus.app_addr), 256'(ea));
        check_val("app_cmd", 256'(bus.app_cmd), 256'(0));
      end
    end
    if (rst_n && bus.app_wdf_wren && bus.app_wdf_rdy) begin
      n_wdf_acc++;
      check_val("beat_expected", 256'(exp_beat.size() != 0), 256'(1));
      if (exp_beat.size() != 0) begin
        eb = exp_beat.pop_front();
        check_val("app_wdf_data", bus.app_wdf_data, eb.data);
        check_val("app_wdf_end", 256'(bus.app_wdf_end), 256'(eb.last));
      end
    end
    if (bus.cmd_fifo_rd_en) begin
      n_cmd_pop++;
      check_val("cmd_fifo_nonempty", 256'(cmdq.size() != 0), 256'(1));
      if (cmdq.size() != 0) next_cmd = cmdq.pop_front();
    end
    if (bus.data_fifo_rd_en) begin
      n_data_pop++;
      check_val("data_fifo_nonempty", 256'(dataq.size() != 0), 256'(1));
      if (dataq.size() != 0) next_data = dataq.pop_front();
    end
    @(posedge clk_ram);
    #1;
    bus.cmd_fifo_rd_data  = next_cmd;
    bus.data_fifo_rd_data = next_data;
    update_sizes();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check_val("idle_within_budget", 256'(busy), 256'(0));
  endtask

  task automatic wait_app_en(input int budget);
    int n;
    n = 0;
    while (!bus.app_en && n < budget) begin
      tick();
      n++;
    end
    check_val("app_en_within_budget", 256'(bus.app_en), 256'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"}, 256'(busy), 256'(0));
    check_val({tag, "_app_en"}, 256'(bus.app_en), 256'(0));
    check_val({tag, "_wren"}, 256'(bus.app_wdf_wren), 256'(0));
    check_val({tag, "_end"}, 256'(bus.app_wdf_end), 256'(0));
    check_val({tag, "_addr"}, 256'(bus.app_addr), 256'(0));
    check_val({tag, "_cmd"}, 256'(bus.app_cmd), 256'(0));
    check_val({tag, "_wdata"}, bus.app_wdf_data, 256'(0));
    check_val({tag, "_cmd_err"}, 256'(cmd_err), 256'(0));
    check_val({tag, "_bursts"}, 256'(bursts_done), 256'(0));
    check_val({tag, "_stalls"}, 256'(stall_cycles), 256'(0));
    check_val({tag, "_rd_en"}, 256'({bus.cmd_fifo_rd_en, bus.data_fifo_rd_en}), 256'(0));
    check_val({tag, "_mask"}, 256'(bus.app_wdf_mask), 256'(0));
    check_val({tag, "_maint"}, 256'({bus.app_ref_req, bus.app_sr_req, bus.app_zq_req}), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] da, db, dc, dd;
    da = {8{32'hAAAA_0001}};
    db = {8{32'hBBBB_0002}};
    dc = {8{32'hCCCC_0003}};
    dd = {8{32'hDDDD_0004}};

    rst_n = 1'b0;
    enable = 1'b0;
    bus.app_rdy = 1'b1;
    bus.app_wdf_rdy = 1'b1;
    bus.cmd_fifo_rd_data = '0;
    bus.data_fifo_rd_data = '0;
    update_sizes();
    clear_stats();
    exp_bursts = '0;
    exp_stall = '0;
    tick();
    tick();
    check_reset_outputs("reset");

    // Single burst, MIG always ready; cycle 0 is the first cycle the start condition holds.
    rst_n = 1'b1;
    enable = 1'b1;
    push_burst(29'h1000, da, db);
    tick();
    check_val("pop0_cmd_rd_en", 256'(bus.cmd_fifo_rd_en), 256'(1));
    check_val("pop0_data_rd_en", 256'(bus.data_fifo_rd_en), 256'(1));
    tick();
    tick();
    check_val("capt_app_en_low", 256'(bus.app_en), 256'(0));
    tick();
    check_val("c4_app_en", 256'(bus.app_en), 256'(1));
    check_val("c4_addr", 256'(bus.app_addr), 256'(29'h1000));
    check_val("c4_wren", 256'(bus.app_wdf_wren), 256'(1));
    check_val("c4_wdata", bus.app_wdf_data, da);
    check_val("c4_end", 256'(bus.app_wdf_end), 256'(0));
    tick();
    check_val("c5_app_en", 256'(bus.app_en), 256'(0));
    check_val("c5_wdata", bus.app_wdf_data, db);
    check_val("c5_end", 256'(bus.app_wdf_end), 256'(1));
    tick();
    exp_bursts = exp_bursts + 1;
    check_val("c6_busy", 256'(busy), 256'(0));
    check_val("single_bursts", 256'(bursts_done), 256'(exp_bursts));

    // Backpressure: command port stalled 3 cycles, data port stalled 5 cycles.
    clear_stats();
    bus.app_rdy = 1'b0;
    bus.app_wdf_rdy = 1'b0;
    push_burst(29'h0ABCDE0, dc, dd);
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.app_rdy = 1'b1;
      check_val("bp_app_en_held", 256'(bus.app_en), 256'(1));
      check_val("bp_addr_held", 256'(bus.app_addr), 256'(29'h0ABCDE0));
      check_val("bp_wdata_held", bus.app_wdf_data, dc);
      tick();
    end
    check_val("bp_c8_app_en", 256'(bus.app_en), 256'(0));
    check_val("bp_c8_wdata_held", bus.app_wdf_data, dc);
    tick();
    bus.app_wdf_rdy = 1'b1;
    tick();
    check_val("bp_c10_end", 256'(bus.app_wdf_end), 256'(1));
    check_val("bp_c10_busy", 256'(busy), 256'(1));
    tick();
    exp_bursts = exp_bursts + 1;
    exp_stall = exp_stall + 5;
    check_val("bp_c11_busy", 256'(busy), 256'(0));
    check_val("bp_cmd_accepts", 256'(n_cmd_acc), 256'(1));
    check_val("bp_beat_accepts", 256'(n_wdf_acc), 256'(2));
    check_val("bp_stalls", 256'(stall_cycles), 256'(exp_stall));
    check_val("bp_bursts", 256'(bursts_done), 256'(exp_bursts));

    // Insufficient data: one command but only one data word.
    clear_stats();
    cmdq.push_back({1'b0, 29'h2000});
    dataq.push_back(da);
    update_sizes();
    repeat (5) tick();
    check_val("short_no_cmd_pop", 256'(n_cmd_pop), 256'(0));
    check_val("short_no_data_pop", 256'(n_data_pop), 256'(0));
    check_val("short_idle", 256'(busy), 256'(0));
    dataq.push_back(db);
    exp_addr.push_back(29'h2000);
    exp_beat.push_back('{data: da, last: 1'b0});
    exp_beat.push_back('{data: db, last: 1'b1});
    update_sizes();
    tick();
    check_val("short_pop0", 256'(bus.cmd_fifo_rd_en), 256'(1));
    wait_idle(20);
    exp_bursts = exp_bursts + 1;
    check_val("short_bursts", 256'(bursts_done), 256'(exp_bursts));

    // Read command is dropped and flagged.
    clear_stats();
    cmdq.push_back({1'b1, 29'h3000});
    dataq.push_back(dc);
    dataq.push_back(dd);
    update_sizes();
    repeat (8) tick();
    check_val("rd_cmd_err", 256'(cmd_err), 256'(1));
    check_val("rd_cmd_pops", 256'(n_cmd_pop), 256'(1));
    check_val("rd_data_pops", 256'(n_data_pop), 256'(2));
    check_val("rd_no_app_en", 256'(saw_app_en), 256'(0));
    check_val("rd_no_wren", 256'(saw_wren), 256'(0));
    check_val("rd_bursts", 256'(bursts_done), 256'(exp_bursts));
    repeat (3) tick();
    check_val("rd_cmd_err_sticky", 256'(cmd_err), 256'(1));

    // Enable dropped during ISSUE: burst finishes, nothing new starts.
    push_burst(29'h4000, da, dc);
    push_burst(29'h4008, db, dd);
    wait_app_en(20);
    enable = 1'b0;
    wait_idle(20);
    exp_bursts = exp_bursts + 1;
    check_val("en_bursts", 256'(bursts_done), 256'(exp_bursts));
    clear_stats();
    repeat (10) tick();
    check_val("en_held_idle", 256'(busy), 256'(0));
    check_val("en_no_pops", 256'(n_cmd_pop + n_data_pop), 256'(0));
    enable = 1'b1;
    tick();
    check_val("en_restart", 256'(busy), 256'(1));
    wait_idle(20);
    exp_bursts = exp_bursts + 1;
    check_val("en_bursts2", 256'(bursts_done), 256'(exp_bursts));

    // Reset asserted while in POP1.
    push_burst(29'h5000, dc, da);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    exp_addr.delete();
    exp_beat.delete();
    exp_bursts = '0;
    exp_stall = '0;
    tick();
    check_val("midrst_fifos_drained", 256'(cmdq.size() + dataq.size()), 256'(0));

    // Eight queued bursts back to back.
    clear_stats();
    for (int k = 0; k < 8; k++)
      push_burst(29'(32'h100 * k + 32'h10), {8{32'h1000_0000 + 32'(k)}}, {8{32'h2000_0000 + 32'(k)}});
    for (int c = 1; c <= 48; c++) begin
      tick();
      if (c == 47) begin
        check_val("b2b_c47_busy", 256'(busy), 256'(1));
        check_val("b2b_c47_bursts", 256'(bursts_done), 256'(7));
      end
    end
    exp_bursts = exp_bursts + 8;
    check_val("b2b_c48_busy", 256'(busy), 256'(0));
    check_val("b2b_bursts", 256'(bursts_done), 256'(exp_bursts));
    check_val("b2b_cmd_accepts", 256'(n_cmd_acc), 256'(8));
    check_val("b2b_stalls", 256'(stall_cycles), 256'(exp_stall));
    check_val("sb_addr_drained", 256'(exp_addr.size()), 256'(0));
    check_val("sb_beats_drained", 256'(exp_beat.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
